// File: rtl/decode_stage_sb.sv
// decode_stage_sb: registered, handshaked decode stage with GPR/FPR files, write-back port
// and a per-register busy scoreboard that stalls on read-after-write hazards.
module decode_stage_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int BRAM_SIZE = 18,
    parameter int SP_IDX = 29,
    parameter logic [XLEN-1:0] SP_INIT = 32'h1FFFC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          inst,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [5:0]           instr,
    output logic [XLEN-1:0]      s,
    output logic [XLEN-1:0]      t,
    output logic [XLEN-1:0]      imm,
    output logic [4:0]           h,
    output logic [BRAM_SIZE-1:0] addra,
    output logic                 rea,
    output logic                 wea,
    output logic [1:0]           is_sorf,
    output logic                 dest_en,
    output logic                 dest_fp,
    output logic [4:0]           destreg,
    output logic [XLEN-1:0]      lreg,
    input  logic                 wb_en,
    input  logic                 wb_fp,
    input  logic [4:0]           wb_addr,
    input  logic [XLEN-1:0]      wb_data
);
    localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
    localparam logic [5:0] OP_BLEZ = 6'h06, OP_BGTZ = 6'h07, OP_ADDI = 6'h08, OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F;
    localparam logic [5:0] OP_FPU = 6'h11, OP_LUIS = 6'h1F, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] OP_LWS = 6'h31, OP_SWS = 6'h39;
    localparam logic [5:0] FN_JR = 6'h08, FN_ITOF = 6'h20, FN_FTOI = 6'h24;
    localparam logic [5:0] FN_EQ = 6'h32, FN_LT = 6'h3C, FN_LE = 6'h3E;

    logic [XLEN-1:0] gpr [NREG];
    logic [XLEN-1:0] fpr [NREG];
    logic [NREG-1:0] busy_g, busy_f;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sh;
    logic is_sp, is_fpu, gpr_rt, fpu_gpr, s_fp, hazard, accept, fire;
    logic d_dest_en, d_dest_fp;
    logic [4:0] d_dest, s_idx;
    logic [XLEN-1:0] sext, d_imm, d_s, d_t, sum;

    // $0 reads as zero; any entry written back this cycle is forwarded
    function automatic logic [XLEN-1:0] rd_port(input logic fp, input logic [4:0] idx);
        if (!fp && idx == 5'd0) return '0;
        if (wb_en && wb_fp == fp && wb_addr == idx) return wb_data;
        return fp ? fpr[idx] : gpr[idx];
    endfunction

    function automatic logic src_hazard(input logic fp, input logic [4:0] idx);
        return !(!fp && idx == 5'd0) &&
               (((fp ? busy_f[idx] : busy_g[idx]) && !(wb_en && wb_fp == fp && wb_addr == idx)) ||
                (out_valid && dest_en && dest_fp == fp && destreg == idx));
    endfunction

    always_comb begin
        op = inst[31:26];
        fn = inst[5:0];
        rs = inst[25:21];
        rt = inst[20:16];
        rd = inst[15:11];
        sh = inst[10:6];
        is_sp = op == 6'h00;
        is_fpu = op == OP_FPU;
        gpr_rt = op inside {OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI, OP_LW};
        fpu_gpr = fn inside {FN_FTOI, FN_EQ, FN_LT, FN_LE};
        d_dest_en = (is_sp && fn != FN_JR) || gpr_rt || op == OP_JAL || is_fpu || op == OP_LWS || op == OP_LUIS;
        d_dest_fp = (is_fpu && !fpu_gpr) || op == OP_LWS || op == OP_LUIS;
        d_dest = !d_dest_en ? 5'd0 : is_sp ? rd : is_fpu ? sh : op == OP_JAL ? 5'd31 : rt;
        sext = {{(XLEN-16){inst[15]}}, inst[15:0]};
        d_imm = (op == OP_J || op == OP_JAL) ? {{(XLEN-26){1'b0}}, inst[25:0]} :
                (op inside {OP_LUI, OP_BEQ, OP_BNE, OP_BGTZ, OP_BLEZ}) ? {{(XLEN-16){1'b0}}, inst[15:0]} : sext;
        s_fp = is_fpu && fn != FN_ITOF;
        s_idx = is_fpu ? rd : rs;
        d_s = rd_port(s_fp, s_idx);
        d_t = rd_port(is_fpu, rt);
        sum = rd_port(1'b0, rs) + sext;
        hazard = src_hazard(s_fp, s_idx) || src_hazard(is_fpu, rt);
        in_ready = !flush && !hazard && (!out_valid || out_ready);
        accept = in_valid && in_ready;
        fire = out_valid && out_ready && !flush;
        lreg = rd_port(1'b0, 5'd31);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                gpr[i] <= (i == SP_IDX) ? SP_INIT : '0;
                fpr[i] <= '0;
            end
        end else if (wb_en) begin
            if (wb_fp) fpr[wb_addr] <= wb_data;
            else if (wb_addr != 5'd0) gpr[wb_addr] <= wb_data;
        end
    end

    // the set is issued after the clear so a same-cycle set on one entry wins
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_g <= '0;
            busy_f <= '0;
        end else begin
            if (wb_en) begin
                if (wb_fp) busy_f[wb_addr] <= 1'b0;
                else busy_g[wb_addr] <= 1'b0;
            end
            if (fire && dest_en) begin
                if (dest_fp) busy_f[destreg] <= 1'b1;
                else if (destreg != 5'd0) busy_g[destreg] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            instr <= '0;
            s <= '0;
            t <= '0;
            imm <= '0;
            h <= '0;
            addra <= '0;
            rea <= 1'b0;
            wea <= 1'b0;
            is_sorf <= '0;
            dest_en <= 1'b0;
            dest_fp <= 1'b0;
            destreg <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            instr <= (is_sp || is_fpu) ? fn : op;
            s <= d_s;
            t <= d_t;
            imm <= d_imm;
            h <= sh;
            addra <= sum[BRAM_SIZE+1:2];
            rea <= op == OP_LW || op == OP_LWS;
            wea <= op == OP_SW || op == OP_SWS;
            is_sorf <= {is_fpu, is_sp};
            dest_en <= d_dest_en;
            dest_fp <= d_dest_fp;
            destreg <= d_dest;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
